// File: rtl/cs_symbol_serializer.sv
// Frame FIFO + symbol serializer behind the cyclic-shift encoder; streams K symbols per frame.
// Optional CS_SER_DROP_CNT_EN adds a saturating dropped-frame counter output (drop_cnt).
module cs_symbol_serializer #(
  parameter int unsigned K     = 3,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     coded_in [K],
  input  logic                 out_ready,
  input  logic                 clr_overflow,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [$clog2(K)-1:0] out_idx,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 full,
`ifdef CS_SER_DROP_CNT_EN
  output logic [15:0]          drop_cnt,
`endif
  output logic                 overflow
);

  localparam int unsigned IdxW = $clog2(K);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(K - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] OneCnt   = CntW'(1);

  typedef enum logic [0:0] {StEmpty, StSend} state_e;

  logic [WIDTH-1:0] mem_q [DEPTH][K];
  state_e           state_q, state_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [IdxW-1:0]  sym_idx_q, sym_idx_d;
  logic             overflow_q, overflow_d;
  logic             beat, pop, wr_en, drop;

  always_comb begin
    out_valid = (state_q == StSend);
    beat      = out_valid && out_ready;
    pop       = beat && (sym_idx_q == LastIdx);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    wr_en     = valid_in && ((count_q != DepthCnt) || pop);
    drop      = valid_in && !wr_en;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    sym_idx_d  = sym_idx_q;
    overflow_d = drop | (overflow_q & ~clr_overflow);

    if (beat) sym_idx_d = pop ? '0 : sym_idx_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;

    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      StEmpty: if (wr_en) state_d = StSend;
      StSend:  if (pop && !wr_en && (count_q == OneCnt)) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sym_idx_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sym_idx_q  <= sym_idx_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= coded_in;
  end

  // Gated by out_valid so unreset storage never reaches out_data.
  always_comb begin
    out_data = out_valid ? mem_q[rd_ptr_q][sym_idx_q] : '0;
    out_idx  = sym_idx_q;
    out_sof  = out_valid && (sym_idx_q == '0);
    out_eof  = out_valid && (sym_idx_q == LastIdx);
    full     = (count_q == DepthCnt);
    overflow = overflow_q;
  end

`ifdef CS_SER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_overflow) begin
      drop_cnt_d = {15'd0, drop};
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cs_symbol_serializer.sv
// Self-checking bench for cs_symbol_serializer: queue-of-frames reference model, random stimulus.
// Build with CS_SER_DROP_CNT_EN to also check drop_cnt.
module tb_cs_symbol_serializer;
  localparam int K  = 3;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int IW = $clog2(K);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic out_ready = 1'b0;
  logic clr_overflow = 1'b0;
  logic [K*W-1:0] cur_frame = '0;
  logic [W-1:0] coded_in [K];
  logic out_valid, out_sof, out_eof, full, overflow;
  logic [W-1:0] out_data;
  logic [IW-1:0] out_idx;
`ifdef CS_SER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  cs_symbol_serializer #(.K(K), .WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .coded_in     (coded_in),
    .out_ready    (out_ready),
    .clr_overflow (clr_overflow),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_idx      (out_idx),
    .out_sof      (out_sof),
    .out_eof      (out_eof),
    .full         (full),
`ifdef CS_SER_DROP_CNT_EN
    .drop_cnt     (drop_cnt),
`endif
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < K; i++) coded_in[i] = cur_frame[i*W +: W];
  end

  // Reference model: frames waiting, symbol position in head frame, sticky flag, drop count.
  logic [K*W-1:0]    mq[$];
  int                m_idx;
  bit                m_ovf;
  int                m_drops;
  logic [IW+W+1:0]   obs[$];
  logic [IW+W+1:0]   exp_q[$];
  int                checks = 0;
  int                errors = 0;

  function automatic logic [W-1:0] sym(input logic [K*W-1:0] f, input int i);
    return f[i*W +: W];
  endfunction

  task automatic model_reset();
    mq.delete();
    obs.delete();
    exp_q.delete();
    m_idx   = 0;
    m_ovf   = 0;
    m_drops = 0;
  endtask

  // Called just after a falling edge; records the beat, advances the model, steps one cycle.
  task automatic tick();
    bit beat, pop, wr, drop;
    if (out_valid && out_ready) obs.push_back({out_idx, out_data, out_sof, out_eof});
    beat = (mq.size() > 0) && out_ready;
    pop  = beat && (m_idx == K - 1);
    if (beat) exp_q.push_back({IW'(m_idx), sym(mq[0], m_idx), m_idx == 0, m_idx == K - 1});
    wr   = valid_in && ((mq.size() < D) || pop);
    drop = valid_in && !wr;
    if (beat) begin
      if (pop) begin
        void'(mq.pop_front());
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    if (wr) mq.push_back(cur_frame);
    if (clr_overflow) m_drops = drop ? 1 : 0;
    else if (drop && m_drops < 65535) m_drops++;
    m_ovf = drop ? 1'b1 : (clr_overflow ? 1'b0 : m_ovf);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    valid_in  = 1'b0;
    out_ready = 1'b1;
    repeat (D * K + 2) tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_idx, out_sof, out_eof, full, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %b, expected all zero",
               {out_valid, out_data, out_idx, out_sof, out_eof, full, overflow});
    end
`ifdef CS_SER_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_drop_cnt: got %0d, expected 0", drop_cnt);
    end
`endif
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_single();
    logic [IW+W+1:0] want [3];
    want[0] = {IW'(0), 4'hA, 1'b1, 1'b0};
    want[1] = {IW'(1), 4'h5, 1'b0, 1'b0};
    want[2] = {IW'(2), 4'h3, 1'b0, 1'b1};
    obs.delete();
    exp_q.delete();
    out_ready = 1'b1;
    valid_in  = 1'b1;
    cur_frame = {4'h3, 4'h5, 4'hA};
    tick();
    valid_in = 1'b0;
    checks++;
    if ({out_valid, out_idx, out_data, out_sof} !== {1'b1, IW'(0), 4'hA, 1'b1}) begin
      errors++;
      $display("FAIL single_latency: got v=%b idx=%0d data=%h sof=%b, expected v=1 idx=0 data=a sof=1",
               out_valid, out_idx, out_data, out_sof);
    end
    repeat (3) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got out_valid=%b, expected 0", out_valid);
    end
    checks++;
    if (obs.size() != 3) begin
      errors++;
      $display("FAIL single_len: got %0d beats, expected 3", obs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== want[i]) begin
          errors++;
          $display("FAIL single_beat%0d: got %h, expected %h", i, obs[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    obs.delete();
    exp_q.delete();
    out_ready = 1'b0;
    valid_in  = 1'b1;
    cur_frame = {4'h3, 4'h5, 4'hA};
    tick();
    valid_in = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({out_valid, out_data, out_idx} !== {1'b1, 4'hA, IW'(0)}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got v=%b data=%h idx=%0d, expected v=1 data=a idx=0",
                 c, out_valid, out_data, out_idx);
      end
      tick();
    end
    drain();
    checks++;
    if (obs.size() != exp_q.size() || obs.size() != K) begin
      errors++;
      $display("FAIL hold_len: got %0d beats, expected %0d", obs.size(), K);
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL hold_beat%0d: got %h, expected %h", i, obs[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    obs.delete();
    exp_q.delete();
    out_ready = 1'b0;
    valid_in  = 1'b1;
    for (int f = 0; f < D; f++) begin
      cur_frame = (K*W)'($urandom());
      tick();
    end
    checks++;
    if ({full, overflow} !== 2'b10) begin
      errors++;
      $display("FAIL ovf_fill: got full=%b overflow=%b, expected full=1 overflow=0", full, overflow);
    end
    cur_frame = (K*W)'($urandom());
    tick();
    valid_in = 1'b0;
    checks++;
    if ({full, overflow} !== 2'b11) begin
      errors++;
      $display("FAIL ovf_drop: got full=%b overflow=%b, expected full=1 overflow=1", full, overflow);
    end
`ifdef CS_SER_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL ovf_drop_cnt: got %0d, expected 1", drop_cnt);
    end
`endif
    drain();
    checks++;
    if (obs.size() != exp_q.size() || obs.size() != D * K) begin
      errors++;
      $display("FAIL ovf_len: got %0d beats, expected %0d", obs.size(), D * K);
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL ovf_beat%0d: got %h, expected %h", i, obs[i], exp_q[i]);
        end
      end
    end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got overflow=%b, expected 0", overflow);
    end
  endtask

  task automatic test_full_pop_write();
    obs.delete();
    exp_q.delete();
    out_ready = 1'b0;
    valid_in  = 1'b1;
    for (int f = 0; f < D; f++) begin
      cur_frame = (K*W)'($urandom());
      tick();
    end
    valid_in  = 1'b0;
    out_ready = 1'b1;
    repeat (K - 1) tick();
    valid_in  = 1'b1;
    cur_frame = (K*W)'($urandom());
    tick();
    valid_in = 1'b0;
    checks++;
    if ({full, overflow} !== 2'b10) begin
      errors++;
      $display("FAIL fpw_flags: got full=%b overflow=%b, expected full=1 overflow=0", full, overflow);
    end
    drain();
    checks++;
    if (obs.size() != exp_q.size() || obs.size() != (D + 1) * K) begin
      errors++;
      $display("FAIL fpw_len: got %0d beats, expected %0d", obs.size(), (D + 1) * K);
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL fpw_beat%0d: got %h, expected %h", i, obs[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_burst();
    obs.delete();
    exp_q.delete();
    out_ready = 1'b1;
    valid_in  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cur_frame = (K*W)'($urandom());
      tick();
    end
    drain();
    checks++;
    if (overflow !== m_ovf) begin
      errors++;
      $display("FAIL burst_overflow: got %b, expected %b", overflow, m_ovf);
    end
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL burst_len: got %0d beats, expected %0d", obs.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL burst_beat%0d: got %h, expected %h", i, obs[i], exp_q[i]);
        end
      end
    end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
  endtask

  task automatic test_random();
    obs.delete();
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      valid_in     = ($urandom_range(1, 0) == 1);
      out_ready    = ($urandom_range(3, 0) != 0);
      clr_overflow = ($urandom_range(15, 0) == 0);
      cur_frame    = (K*W)'($urandom());
      tick();
      checks++;
      if ({out_valid, full, overflow} !== {mq.size() > 0, mq.size() == D, m_ovf}) begin
        errors++;
        $display("FAIL rand_flags@%0d: got v/full/ovf=%b%b%b, expected %b%b%b", c,
                 out_valid, full, overflow, mq.size() > 0, mq.size() == D, m_ovf);
      end
`ifdef CS_SER_DROP_CNT_EN
      checks++;
      if (drop_cnt !== m_drops[15:0]) begin
        errors++;
        $display("FAIL rand_drop_cnt@%0d: got %0d, expected %0d", c, drop_cnt, m_drops);
      end
`endif
    end
    clr_overflow = 1'b0;
    drain();
    checks++;
    if (obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_len: got %0d beats, expected %0d", obs.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_beat%0d: got %h, expected %h", i, obs[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [W-1:0] want [3];
    want[0] = 4'h1;
    want[1] = 4'h2;
    want[2] = 4'h3;
    out_ready = 1'b1;
    valid_in  = 1'b1;
    cur_frame = {4'h9, 4'h8, 4'h7};
    tick();
    valid_in = 1'b0;
    tick();
    checks++;
    if (out_idx !== IW'(1)) begin
      errors++;
      $display("FAIL rst_mid_idx: got %0d, expected 1", out_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_idx, out_sof, out_eof, full, overflow} !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: got %b, expected all zero",
               {out_valid, out_data, out_idx, out_sof, out_eof, full, overflow});
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    valid_in  = 1'b1;
    cur_frame = {4'h3, 4'h2, 4'h1};
    tick();
    drain();
    checks++;
    if (obs.size() != 3) begin
      errors++;
      $display("FAIL rst_mid_len: got %0d beats, expected 3", obs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs[i] !== {IW'(i), want[i], i == 0, i == 2}) begin
          errors++;
          $display("FAIL rst_mid_beat%0d: got %h, expected %h", i, obs[i],
                   {IW'(i), want[i], i == 0, i == 2});
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_pop_write();
    test_burst();
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
